// File: rtl/hidden_cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hidden_cpu_pkg                                                   |
// | Purpose : Shared definitions for the HiddenCPU instruction sequencer:      |
// |           FSM state encodings, the idle (NOP) instruction, the             |
// |           instruction field layout and a saturating counter helper.        |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package hidden_cpu_pkg;

  // Encodings are visible on state_out_o, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Instruction layout seen by the core: {op[7:6], rA[5:4], rB[3:2], xx[1:0]}.
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] xx;
  } instr_t;

  localparam logic [7:0] NOP_INSTR_DEFAULT = 8'h00;

  // Issue counter stops at 255 rather than wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hidden_cpu_imem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hidden_cpu_imem                                                  |
// | Purpose : DEPTH x 8 program memory. Synchronous write, two asynchronous    |
// |           read ports (current PC and next issue address). Not reset.      |
// | Ports   : clk                  clock                                       |
// |           we_i/waddr_i/wdata_i write port                                  |
// |           raddr_a_i/rdata_a_o  read port A                                 |
// |           raddr_b_i/rdata_b_o  read port B                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hidden_cpu_imem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [7:0]    rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [7:0]    rdata_b_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/hidden_cpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : hidden_cpu_sequencer                                             |
// | Purpose : Instruction sequencer for the 8-bit HiddenCPU core. Loads a      |
// |           program byte-serially, then issues one instruction per clock,   |
// |           following branch redirects from the core. Run/pause/step/abort. |
// | Ports   : clk, rst (async, active high)                                    |
// |           abort_i, load_start_i, run_i, step_i, pause_req_i   commands    |
// |           load_valid_i/load_last_i/load_data_i/load_ready_o   load port   |
// |           branch_taken_i/branch_offset_i                      core redirect|
// |           instr_out_o/instr_valid_o/pc_out_o                  issue port  |
// |           state_out_o/done_o/issue_count_o                    status      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module hidden_cpu_sequencer
  import hidden_cpu_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter int         AW        = $clog2(DEPTH),
  parameter logic [7:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort_i,
  input  logic       load_start_i,
  input  logic       load_valid_i,
  input  logic       load_last_i,
  input  logic [7:0] load_data_i,
  output logic       load_ready_o,
  input  logic       run_i,
  input  logic       step_i,
  input  logic       pause_req_i,
  input  logic       branch_taken_i,
  input  logic [7:0] branch_offset_i,
  output logic [7:0] instr_out_o,
  output logic       instr_valid_o,
  output logic [7:0] pc_out_o,
  output logic [2:0] state_out_o,
  output logic       done_o,
  output logic [7:0] issue_count_o
);

  state_t        state_q,    state_d;
  logic [7:0]    pc_q,       pc_d;
  instr_t        instr_q,    instr_d;
  logic          valid_q,    valid_d;
  logic          done_q,     done_d;
  logic          step_q,     step_d;     // current issue is a single step
  logic [7:0]    cnt_q,      cnt_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [AW:0]   prog_len_q, prog_len_d; // needs AW+1 bits to hold DEPTH

  logic          mem_we;
  logic [7:0]    npc;
  logic          npc_end;
  logic          has_prog;
  logic [AW-1:0] issue_addr;
  logic [7:0]    rd_pc;
  logic [7:0]    rd_issue;

  // Branches only count while an instruction is actually live.
  assign npc      = (branch_taken_i && valid_q) ? (pc_q + branch_offset_i) : (pc_q + 8'd1);
  assign npc_end  = {1'b0, npc} >= 9'(prog_len_q);
  assign has_prog = (prog_len_q != '0);

  // Port B serves both the in-run next issue and the run-from-0 first issue.
  assign issue_addr = (state_q == ST_RUN) ? npc[AW-1:0] : '0;

  hidden_cpu_imem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk       (clk),
    .we_i      (mem_we),
    .waddr_i   (wr_ptr_q),
    .wdata_i   (load_data_i),
    .raddr_a_i (pc_q[AW-1:0]),
    .rdata_a_o (rd_pc),
    .raddr_b_i (issue_addr),
    .rdata_b_o (rd_issue)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    done_d     = done_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    mem_we     = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      done_d  = 1'b0;
      step_d  = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_valid_i) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (load_last_i || (wr_ptr_q == {AW{1'b1}})) begin
              prog_len_d = {1'b0, wr_ptr_q} + {{AW{1'b0}}, 1'b1};
              state_d    = ST_IDLE;
            end
          end
        end

        ST_IDLE, ST_DONE: begin
          if (load_start_i) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
            done_d   = 1'b0;
          end else if ((run_i || step_i) && has_prog) begin
            state_d = ST_RUN;
            pc_d    = 8'd0;
            instr_d = rd_issue;
            valid_d = 1'b1;
            cnt_d   = 8'd1;
            done_d  = 1'b0;
            step_d  = !run_i;
          end
        end

        ST_PAUSE: begin
          if (load_start_i) begin
            state_d  = ST_LOAD;
            wr_ptr_d = '0;
          end else if ((run_i || step_i) && has_prog) begin
            // Resume issues the already-evaluated PC; no new npc here.
            state_d = ST_RUN;
            instr_d = rd_pc;
            valid_d = 1'b1;
            cnt_d   = sat_inc8(cnt_q);
            step_d  = !run_i;
          end
        end

        ST_RUN: begin
          if (npc_end) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            step_d  = 1'b0;
          end else if (pause_req_i || step_q) begin
            // pc parks on the next instruction to issue.
            state_d = ST_PAUSE;
            pc_d    = npc;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            step_d  = 1'b0;
          end else begin
            pc_d    = npc;
            instr_d = rd_issue;
            cnt_d   = sat_inc8(cnt_q);
          end
        end

        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          done_d  = 1'b0;
          step_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= 8'd0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= 1'b0;
      cnt_q      <= 8'd0;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
    end
  end

  assign load_ready_o  = (state_q == ST_LOAD);
  assign instr_out_o   = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_out_o      = pc_q;
  assign state_out_o   = state_q;
  assign done_o        = done_q;
  assign issue_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hidden_cpu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_hidden_cpu_sequencer                                          |
// | Purpose : Self-checking bench for hidden_cpu_sequencer: directed scenarios |
// |           followed by random commands, compared each cycle against a      |
// |           behavioural model of the sequencer's rules.                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_hidden_cpu_sequencer;

  localparam int DEPTH = 16;
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2, S_PAUSE = 3, S_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort_i = 0, load_start_i = 0, load_valid_i = 0, load_last_i = 0;
  logic [7:0] load_data_i = 0;
  logic       run_i = 0, step_i = 0, pause_req_i = 0, branch_taken_i = 0;
  logic [7:0] branch_offset_i = 0;
  logic       load_ready_o, instr_valid_o, done_o;
  logic [7:0] instr_out_o, pc_out_o, issue_count_o;
  logic [2:0] state_out_o;

  always #5 clk = ~clk;

  hidden_cpu_sequencer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .abort_i         (abort_i),
    .load_start_i    (load_start_i),
    .load_valid_i    (load_valid_i),
    .load_last_i     (load_last_i),
    .load_data_i     (load_data_i),
    .load_ready_o    (load_ready_o),
    .run_i           (run_i),
    .step_i          (step_i),
    .pause_req_i     (pause_req_i),
    .branch_taken_i  (branch_taken_i),
    .branch_offset_i (branch_offset_i),
    .instr_out_o     (instr_out_o),
    .instr_valid_o   (instr_valid_o),
    .pc_out_o        (pc_out_o),
    .state_out_o     (state_out_o),
    .done_o          (done_o),
    .issue_count_o   (issue_count_o)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int         m_state, m_pc, m_cnt, m_len, m_wp;
  logic [7:0] m_instr;
  logic       m_valid, m_done, m_single;
  logic [7:0] m_mem [DEPTH];

  task automatic model_reset();
    m_state = S_IDLE; m_pc = 0; m_cnt = 0; m_len = 0; m_wp = 0;
    m_instr = 8'h00; m_valid = 0; m_done = 0; m_single = 0;
  endtask

  task automatic model_issue(input int pc);
    m_state = S_RUN; m_pc = pc; m_instr = m_mem[pc]; m_valid = 1;
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask

  // Applies one clock edge worth of the sequencer rules to the model.
  task automatic model_step();
    int npc;
    if (abort_i) begin
      m_state = S_IDLE; m_valid = 0; m_instr = 8'h00; m_done = 0; m_single = 0;
    end else if (m_state == S_LOAD) begin
      if (load_valid_i) begin
        m_mem[m_wp] = load_data_i;
        if (load_last_i || m_wp == DEPTH - 1) begin
          m_len = m_wp + 1; m_state = S_IDLE;
        end
        m_wp = (m_wp + 1) % DEPTH;
      end
    end else if (m_state == S_IDLE || m_state == S_DONE || m_state == S_PAUSE) begin
      if (load_start_i) begin
        m_state = S_LOAD; m_wp = 0; m_done = 0;
      end else if ((run_i || step_i) && m_len > 0) begin
        if (m_state == S_PAUSE) model_issue(m_pc);
        else begin m_cnt = 0; model_issue(0); end
        m_done = 0; m_single = !run_i;
      end
    end else begin // RUN
      npc = (m_pc + (branch_taken_i ? int'(branch_offset_i) : 1)) % 256;
      if (npc >= m_len) begin
        m_state = S_DONE; m_done = 1; m_valid = 0; m_instr = 8'h00; m_single = 0;
      end else if (pause_req_i || m_single) begin
        m_state = S_PAUSE; m_pc = npc; m_valid = 0; m_instr = 8'h00; m_single = 0;
      end else begin
        model_issue(npc);
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},      32'(state_out_o),   32'(m_state));
    chk({tag, ".valid"},      32'(instr_valid_o), 32'(m_valid));
    chk({tag, ".instr"},      32'(instr_out_o),   32'(m_instr));
    chk({tag, ".done"},       32'(done_o),        32'(m_done));
    chk({tag, ".count"},      32'(issue_count_o), 32'(m_cnt));
    chk({tag, ".load_ready"}, 32'(load_ready_o),  32'(m_state == S_LOAD));
    if (m_valid || m_state == S_PAUSE)
      chk({tag, ".pc"}, 32'(pc_out_o), 32'(m_pc));
  endtask

  // One clock: model sees the same inputs the DUT samples, then compare.
  task automatic cyc(input string tag);
    model_step();
    @(posedge clk); #1;
    check_all(tag);
    abort_i = 0; load_start_i = 0; load_valid_i = 0; load_last_i = 0;
    run_i = 0; step_i = 0; pause_req_i = 0; branch_taken_i = 0; branch_offset_i = 0;
  endtask

  task automatic load_prog(input logic [7:0] bytes [$], input bit use_last);
    load_start_i = 1; cyc("ld_start");
    for (int i = 0; i < bytes.size(); i++) begin
      load_valid_i = 1; load_data_i = bytes[i];
      load_last_i  = use_last && (i == bytes.size() - 1);
      cyc("ld_byte");
    end
  endtask

  task automatic run_to_stop(input string tag, input int limit);
    int n = 0;
    while (m_state == S_RUN && n < limit) begin cyc(tag); n++; end
    if (m_state == S_RUN) begin
      checks++; failures++;
      $display("FAIL %s.timeout observed=still_running expected=stopped", tag);
    end
  endtask

  logic [7:0] prog4 [$];
  logic [7:0] progf [$];
  logic [7:0] br_off [6];
  logic       br_en  [6];
  int         br_pc  [6];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.pc", 32'(pc_out_o), 32'd0);
    rst = 0;

    // Basic 4-byte program, then run to the end.
    prog4 = '{8'h10, 8'h24, 8'h38, 8'h4C};
    load_prog(prog4, 1'b1);
    chk("load4.ready_after", 32'(load_ready_o), 32'd0);
    chk("load4.idle", 32'(state_out_o), 32'(S_IDLE));
    run_i = 1; cyc("run4");
    chk("run4.i0", 32'(instr_out_o), 32'h10);
    cyc("run4"); chk("run4.i1", 32'(instr_out_o), 32'h24);
    cyc("run4"); chk("run4.i2", 32'(instr_out_o), 32'h38);
    cyc("run4"); chk("run4.i3", 32'(instr_out_o), 32'h4C);
    cyc("run4");
    chk("run4.done", 32'(done_o), 32'd1);
    chk("run4.valid", 32'(instr_valid_o), 32'd0);
    chk("run4.count", 32'(issue_count_o), 32'd4);

    // Full-depth load without load_last, then a stray byte in IDLE.
    for (int i = 0; i < DEPTH; i++) progf.push_back(8'($urandom_range(0, 200)));
    load_prog(progf, 1'b0);
    chk("loadfull.idle", 32'(state_out_o), 32'(S_IDLE));
    load_valid_i = 1; load_data_i = 8'hEE; cyc("stray_byte");
    run_i = 1; cyc("runfull");
    chk("runfull.first", 32'(instr_out_o), 32'(progf[0]));
    run_to_stop("runfull", 40);
    chk("runfull.count", 32'(issue_count_o), 32'd16);

    // Branches: pcs 0 ->(+2) 2 -> 3 ->(+FD) 0 -> 1 -> 2 ->(+5) DONE.
    load_prog(prog4, 1'b1);
    br_pc  = '{0, 2, 3, 0, 1, 2};
    br_en  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    br_off = '{8'd2, 8'd0, 8'hFD, 8'd0, 8'd0, 8'd5};
    run_i = 1; cyc("branch");
    for (int i = 0; i < 6; i++) begin
      chk("branch.pc", 32'(pc_out_o), 32'(br_pc[i]));
      branch_taken_i = br_en[i]; branch_offset_i = br_off[i];
      cyc("branch");
    end
    chk("branch.done", 32'(done_o), 32'd1);

    // Pause, single step, resume.
    run_i = 1; cyc("pause"); cyc("pause");
    pause_req_i = 1; cyc("pause");
    chk("pause.state", 32'(state_out_o), 32'(S_PAUSE));
    chk("pause.pc", 32'(pc_out_o), 32'd2);
    step_i = 1; cyc("step");
    chk("step.instr", 32'(instr_out_o), 32'h38);
    cyc("step");
    chk("step.repause", 32'(state_out_o), 32'(S_PAUSE));
    chk("step.pc", 32'(pc_out_o), 32'd3);
    run_i = 1; cyc("resume");
    chk("resume.instr", 32'(instr_out_o), 32'h4C);
    cyc("resume");
    chk("resume.done", 32'(state_out_o), 32'(S_DONE));

    // Abort mid-run keeps the program.
    run_i = 1; cyc("abort"); cyc("abort");
    abort_i = 1; cyc("abort");
    chk("abort.nop", 32'(instr_out_o), 32'h00);
    run_i = 1; cyc("after_abort");
    chk("after_abort.valid", 32'(instr_valid_o), 32'd1);
    abort_i = 1; cyc("abort2");

    // Async reset during load clears prog_len.
    load_start_i = 1; cyc("rstload");
    load_valid_i = 1; load_data_i = 8'h5A; cyc("rstload");
    rst = 1; #1;
    model_reset();
    check_all("rst_mid_load");
    #2 rst = 0;
    run_i = 1; cyc("run_no_prog");
    chk("run_no_prog.state", 32'(state_out_o), 32'(S_IDLE));

    // Command priority.
    load_prog(prog4, 1'b1);
    abort_i = 1; run_i = 1; cyc("abort_vs_run");
    chk("abort_vs_run.state", 32'(state_out_o), 32'(S_IDLE));
    load_start_i = 1; run_i = 1; cyc("load_vs_run");
    chk("load_vs_run.state", 32'(state_out_o), 32'(S_LOAD));
    for (int i = 0; i < 4; i++) begin
      load_valid_i = 1; load_data_i = prog4[i]; load_last_i = (i == 3);
      cyc("load_vs_run.bytes");
    end

    // Self-loop (offset 0) to saturate the issue counter.
    run_i = 1; cyc("sat");
    for (int i = 0; i < 300; i++) begin
      branch_taken_i = 1; branch_offset_i = 8'd0; cyc("sat");
    end
    chk("sat.count", 32'(issue_count_o), 32'd255);
    abort_i = 1; cyc("sat_abort");

    // Random commands against the model.
    for (int i = 0; i < 1500; i++) begin
      abort_i         = ($urandom_range(0, 59) == 0);
      load_start_i    = ($urandom_range(0, 19) == 0);
      run_i           = ($urandom_range(0, 5) == 0);
      step_i          = ($urandom_range(0, 7) == 0);
      pause_req_i     = ($urandom_range(0, 7) == 0);
      load_valid_i    = ($urandom_range(0, 1) == 0);
      load_last_i     = ($urandom_range(0, 4) == 0);
      load_data_i     = 8'($urandom);
      branch_taken_i  = ($urandom_range(0, 3) == 0);
      branch_offset_i = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      cyc("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
